// File: rtl/encoder_quad_decoder.sv
// -----------------------------------------------------------------------------
// encoder_quad_decoder
//
// Quadrature rotary-encoder front end. Synchronizes the asynchronous A/B pins,
// debounces them at the rate of an external one-cycle sample strobe, and
// decodes debounced Gray-code transitions into a wrapping up/down position
// count with a direction bit and a one-cycle step pulse.
//
// Parameters:
//   WIDTH   position counter width (2..16)
//   STABLE  consecutive agreeing strobe samples needed to move the debounced
//           state (1..15)
//
// Ports:
//   clk     in   clock, all state on rising edge
//   rst_n   in   asynchronous active-low reset
//   strobe  in   one-cycle sample enable
//   enc_a   in   encoder channel A (asynchronous)
//   enc_b   in   encoder channel B (asynchronous)
//   clear   in   synchronous clear of value and err
//   value   out  position count, two's-complement wrap
//   dir     out  direction of last counted step (1 = up)
//   step    out  one-cycle pulse per counted step
//   err     out  sticky illegal-transition flag
//
// Build option:
//   ENCODER_QUAD_ERR_EN  when defined, illegal (both-bit) transitions set the
//                        sticky err flag; otherwise err is tied to 0.
// -----------------------------------------------------------------------------
module encoder_quad_decoder #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STABLE = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             strobe,
   input  logic             enc_a,
   input  logic             enc_b,
   input  logic             clear,
   output logic [WIDTH-1:0] value,
   output logic             dir,
   output logic             step,
   output logic             err
);

   localparam logic [3:0]       STABLE_L = 4'(STABLE);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   // Synchronizer and debounce state
   logic [1:0] sync1_q;
   logic [1:0] sync2_q;
   logic [1:0] cand_q;
   logic [3:0] run_q;
   logic [3:0] run_d;
   logic [1:0] deb_q;
   logic [1:0] prev_q;
   logic       primed_q;
   logic       deb_load;

   // Decode
   logic [1:0] pos_new;
   logic [1:0] pos_old;
   logic [1:0] delta;
   logic       changed;
   logic       is_fwd;
   logic       is_rev;
   logic       is_bad;

   // ---------------------------------------------------------------------------
   // Debounce run counter. A sample that disagrees with the candidate restarts
   // the run at 1; an agreeing sample extends it, saturating at STABLE.
   // ---------------------------------------------------------------------------
   always_comb begin
      run_d = run_q;
      if (sync2_q != cand_q) begin
         run_d = 4'd1;
      end else if (run_q < STABLE_L) begin
         run_d = run_q + 4'd1;
      end
   end

   // deb loads on the strobe whose sample makes the run reach STABLE. Once
   // saturated on the same candidate, further strobes are not new loads.
   assign deb_load = strobe && (run_d == STABLE_L) &&
                     ((run_q != STABLE_L) || (sync2_q != cand_q));

   // ---------------------------------------------------------------------------
   // Gray to binary position: 00->0, 01->1, 11->2, 10->3. A forward step is a
   // +1 move modulo 4, reverse is -1, and +2 means both pins changed at once.
   // ---------------------------------------------------------------------------
   always_comb begin
      pos_new = {deb_q[1], deb_q[1] ^ deb_q[0]};
      pos_old = {prev_q[1], prev_q[1] ^ prev_q[0]};
      delta   = pos_new - pos_old;
      changed = primed_q && (deb_q != prev_q);
      is_fwd  = changed && (delta == 2'd1);
      is_rev  = changed && (delta == 2'd3);
      is_bad  = changed && (delta == 2'd2);
   end

   // ---------------------------------------------------------------------------
   // Synchronizer, debounce and priming state
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 2'b00;
         sync2_q  <= 2'b00;
         cand_q   <= 2'b00;
         run_q    <= 4'd0;
         deb_q    <= 2'b00;
         prev_q   <= 2'b00;
         primed_q <= 1'b0;
      end else begin
         sync1_q <= {enc_a, enc_b};
         sync2_q <= sync1_q;

         if (strobe) begin
            cand_q <= sync2_q;
            run_q  <= run_d;
         end

         if (deb_load) begin
            deb_q <= sync2_q;
         end

         // The first debounced state after reset seeds prev directly so that
         // it is never seen as a transition.
         if (deb_load && !primed_q) begin
            prev_q   <= sync2_q;
            primed_q <= 1'b1;
         end else begin
            prev_q <= deb_q;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registered outputs. Clear wins over a simultaneous step for value, but
   // step and dir still report the step.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
         dir   <= 1'b0;
         step  <= 1'b0;
      end else begin
         step <= is_fwd || is_rev;

         if (is_fwd || is_rev) begin
            dir <= is_fwd;
         end

         if (clear) begin
            value <= '0;
         end else if (is_fwd) begin
            value <= value + ONE;
         end else if (is_rev) begin
            value <= value - ONE;
         end
      end
   end

`ifdef ENCODER_QUAD_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (clear) begin
         err <= 1'b0;
      end else if (is_bad) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;

   // Illegal transitions are dropped silently in this build.
   logic unused_bad;
   assign unused_bad = is_bad;
`endif

endmodule

// File: tb/tb_encoder_quad_decoder.sv
module tb_encoder_quad_decoder;

   localparam int WIDTH  = 8;
   localparam int STABLE = 3;

`ifdef ENCODER_QUAD_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic             clk;
   logic             rst_n;
   logic             strobe;
   logic             enc_a;
   logic             enc_b;
   logic             clear;
   logic [WIDTH-1:0] value;
   logic             dir;
   logic             step;
   logic             err;

   int errors;
   int checks;
   int step_cnt;
   int base;

   encoder_quad_decoder #(
      .WIDTH  (WIDTH),
      .STABLE (STABLE)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .strobe (strobe),
      .enc_a  (enc_a),
      .enc_b  (enc_b),
      .clear  (clear),
      .value  (value),
      .dir    (dir),
      .step   (step),
      .err    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts step pulses, sampled away from the active edge.
   initial step_cnt = 0;
   always @(negedge clk) begin
      if (step === 1'b1) step_cnt = step_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp)
      else begin
         errors = errors + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_pins(input logic [1:0] ab);
      enc_a = ab[1];
      enc_b = ab[0];
   endtask

   // n strobe periods of 4 clk each, strobe on the first cycle.
   task automatic strobes(input int n);
      for (int i = 0; i < n; i++) begin
         strobe = 1'b1;
         tick();
         strobe = 1'b0;
         tick();
         tick();
         tick();
      end
   endtask

   // Pins already set. The first strobe still sees the old synchronized value,
   // so the 4th strobe is the 3rd agreeing one; checks the step lands exactly
   // one cycle after it.
   task automatic step_seq(input string tag, input logic [7:0] exp_val, input logic exp_dir);
      strobes(3);
      strobe = 1'b1;
      tick();
      strobe = 1'b0;
      check({tag, " step pre"}, {31'd0, step}, 32'd0);
      tick();
      check({tag, " step"}, {31'd0, step}, 32'd1);
      check({tag, " value"}, {24'd0, value}, {24'd0, exp_val});
      check({tag, " dir"}, {31'd0, dir}, {31'd0, exp_dir});
      tick();
      check({tag, " step post"}, {31'd0, step}, 32'd0);
      tick();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      strobe = 1'b0;
      clear  = 1'b0;
      set_pins(2'b00);
      tick();
      tick();
      check("reset value", {24'd0, value}, 32'd0);
      check("reset dir", {31'd0, dir}, 32'd0);
      check("reset step", {31'd0, step}, 32'd0);
      check("reset err", {31'd0, err}, 32'd0);
      rst_n = 1'b1;

      // Prime on 00: no step
      strobes(4);
      check("prime00 steps", step_cnt, 32'd0);
      check("prime00 value", {24'd0, value}, 32'd0);

      // Forward full cycle
      set_pins(2'b01); step_seq("fwd1", 8'd1, 1'b1);
      set_pins(2'b11); step_seq("fwd2", 8'd2, 1'b1);
      set_pins(2'b10); step_seq("fwd3", 8'd3, 1'b1);
      set_pins(2'b00); step_seq("fwd4", 8'd4, 1'b1);
      check("fwd step count", step_cnt, 32'd4);

      // Clear to 0, then reverse wrap and forward back
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clear value", {24'd0, value}, 32'd0);
      set_pins(2'b10); step_seq("rev wrap", 8'hFF, 1'b0);
      set_pins(2'b00); step_seq("fwd wrap", 8'h00, 1'b1);
      set_pins(2'b01); step_seq("fwd one", 8'h01, 1'b1);
      set_pins(2'b00); step_seq("rev zero", 8'h00, 1'b0);

      // Glitch on A for 2 strobes only reaches 2 agreeing samples
      base = step_cnt;
      set_pins(2'b10);
      strobes(2);
      set_pins(2'b00);
      strobes(4);
      check("glitch steps", step_cnt - base, 32'd0);
      check("glitch value", {24'd0, value}, 32'd0);
      // Debounce still tracks 00 correctly afterwards
      set_pins(2'b01); step_seq("post glitch", 8'h01, 1'b1);

      // Illegal 01 -> 10
      base = step_cnt;
      set_pins(2'b10);
      strobes(4);
      check("illegal steps", step_cnt - base, 32'd0);
      check("illegal value", {24'd0, value}, 32'd1);
      check("illegal dir", {31'd0, dir}, 32'd1);
      check("illegal err", {31'd0, err}, {31'd0, ERR_EN});
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clear err", {31'd0, err}, 32'd0);
      check("clear value2", {24'd0, value}, 32'd0);

      // Clear on the decode edge of forward 10 -> 00
      set_pins(2'b00);
      strobes(3);
      strobe = 1'b1;
      tick();
      strobe = 1'b0;
      clear  = 1'b1;
      tick();
      clear  = 1'b0;
      check("collide value", {24'd0, value}, 32'd0);
      check("collide step", {31'd0, step}, 32'd1);
      check("collide dir", {31'd0, dir}, 32'd1);
      tick();
      tick();

      // Reset mid-debounce with non-zero outputs
      set_pins(2'b01); step_seq("pre reset", 8'h01, 1'b1);
      set_pins(2'b11);
      strobes(2);
      tick();
      rst_n = 1'b0;
      #1;
      check("async rst value", {24'd0, value}, 32'd0);
      check("async rst dir", {31'd0, dir}, 32'd0);
      check("async rst step", {31'd0, step}, 32'd0);
      check("async rst err", {31'd0, err}, 32'd0);

      // Priming with pins held at 11 through reset
      tick();
      tick();
      rst_n = 1'b1;
      base = step_cnt;
      strobes(4);
      check("prime11 steps", step_cnt - base, 32'd0);
      check("prime11 value", {24'd0, value}, 32'd0);
      check("prime11 err", {31'd0, err}, 32'd0);
      set_pins(2'b10); step_seq("after prime", 8'h01, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Safety bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
